// File: rtl/accumulator_pkg.sv
// Shared encodings for the parametrised accumulator: operand selects and FSM states.
package accumulator_pkg;

  typedef enum logic [1:0] {
    SEL_IMM  = 2'b00,
    SEL_REG  = 2'b01,
    SEL_ALU  = 2'b10,
    SEL_RSVD = 2'b11
  } sel_acc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } acc_state_e;

endpackage

// File: rtl/acc_operand_mux.sv
// Operand source select for the accumulator: zero-extended immediate, register file or ALU.
module acc_operand_mux
  import accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 4
) (
  input  logic [1:0]           sel_acc,
  input  logic [IMM_WIDTH-1:0] a_imm,
  input  logic [WIDTH-1:0]     b_reg,
  input  logic [WIDTH-1:0]     b_alu,
  output logic [WIDTH-1:0]     operand
);

  logic [WIDTH-1:0] imm_ext;

  always_comb begin
    imm_ext                = '0;
    imm_ext[IMM_WIDTH-1:0] = a_imm;
  end

  always_comb begin
    // NOTE: every path assigns operand (default arm included), so no latch is inferred.
    case (sel_acc)
      SEL_IMM: operand = imm_ext;
      SEL_REG: operand = b_reg;
      SEL_ALU: operand = b_alu;
      default: operand = '0;
    endcase
  end

endmodule

// File: rtl/param_accumulator.sv
// Handshaked multi-term accumulator: start/num_terms run, valid/ready terms, done/ack result.
// Define ACC_SATURATE_EN to clamp on overflow/underflow instead of wrapping.
module param_accumulator
  import accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int IMM_WIDTH = 4,
  parameter int CNT_W     = 4
) (
  input  logic                 CLK,
  input  logic                 CLB,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_terms,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           SelAcc,
  input  logic                 Sub,
  input  logic [IMM_WIDTH-1:0] A_Imm,
  input  logic [WIDTH-1:0]     B_RegOut,
  input  logic [WIDTH-1:0]     B_AULOut,
  output logic [WIDTH-1:0]     AccOut,
  output logic [CNT_W-1:0]     term_cnt,
  output logic                 acc_done,
  input  logic                 done_ack,
  output logic                 ovf_flag
);

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             transfer;

  acc_operand_mux #(
    .WIDTH    (WIDTH),
    .IMM_WIDTH(IMM_WIDTH)
  ) u_operand_mux (
    .sel_acc(SelAcc),
    .a_imm  (A_Imm),
    .b_reg  (B_RegOut),
    .b_alu  (B_AULOut),
    .operand(operand)
  );

  // Bit WIDTH of the extended result is the carry on add and the borrow on subtract.
  always_comb begin
    if (Sub) sum_ext = {1'b0, acc_q} - {1'b0, operand};
    else     sum_ext = {1'b0, acc_q} + {1'b0, operand};
`ifdef ACC_SATURATE_EN
    if (sum_ext[WIDTH]) acc_next = Sub ? '0 : '1;
    else                acc_next = sum_ext[WIDTH-1:0];
`else
    acc_next = sum_ext[WIDTH-1:0];
`endif
  end

  assign in_ready = (state_q == ST_ACCUM);
  assign acc_done = (state_q == ST_DONE);
  assign transfer = in_valid & in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          num_d   = num_terms;
          state_d = (num_terms == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (transfer) begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | sum_ext[WIDTH];
          if (cnt_inc == num_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (done_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
    end
  end

  assign AccOut   = acc_q;
  assign term_cnt = cnt_q;
  assign ovf_flag = ovf_q;

endmodule
